emu_step_ctrl: RTL and testbench

- Parametrised successor to the single-step emulator clock controller.
- Generates a clock-enable for the emulated analog model and supports single-step, N-step burst and free-run modes, all driven from VIO.
- Captures N_CH model output channels into hold registers after each command so VIO can read a consistent snapshot.
- Sits between the VIO core and the model instance, and runs on the emulator clock.

---
 rtl/emu_step_ctrl.sv | 144 ++++++++++++++
 tb/tb_emu_step_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/emu_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : emu_step_ctrl
// Description : Clock-enable controller for an emulated analog model.
//               Supports single-step, N-step burst and free-run commands
//               from VIO, and snapshots the model outputs after every command.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module emu_step_ctrl #(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 25,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [1:0]              mode,
  input  logic [CNT_WIDTH-1:0]    burst_len,
  input  logic                    stop,
  input  logic                    clr_cnt,
  input  logic [N_CH*WIDTH-1:0]   probe_in,
  output logic                    clk_en,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    step_count,
  output logic [N_CH*WIDTH-1:0]   probe_hold
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  localparam logic [1:0]           MODE_BURST = 2'd1;
  localparam logic [1:0]           MODE_RUN   = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Synchroniser chains; s3 is the edge-detect history for go.
  logic go_s1_q, go_s2_q, go_s3_q, go_pulse_q;
  logic stop_s1_q, stop_s2_q;

  state_e                  state_q, state_d;
  logic                    run_q, run_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic                    clk_en_q, clk_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [N_CH*WIDTH-1:0]   hold_q, hold_d;

  // Synchronise VIO levels; the go edge is registered so a command launches
  // three edges after go is first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_s1_q    <= 1'b0;
      go_s2_q    <= 1'b0;
      go_s3_q    <= 1'b0;
      go_pulse_q <= 1'b0;
      stop_s1_q  <= 1'b0;
      stop_s2_q  <= 1'b0;
    end else begin
      go_s1_q    <= go;
      go_s2_q    <= go_s1_q;
      go_s3_q    <= go_s2_q;
      go_pulse_q <= go_s2_q & ~go_s3_q;
      stop_s1_q  <= stop;
      stop_s2_q  <= stop_s1_q;
    end
  end

  // State, command context, registered outputs and the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      rem_q    <= '0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      rem_q    <= rem_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // registered and line up with the state they describe.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    count_d = count_q;

    // Every enabled cycle is one model step; a clear wins over that step.
    if (clk_en_q) count_d = count_q + CNT_ONE;
    if (clr_cnt)  count_d = '0;

    case (state_q)
      S_IDLE: begin
        if (go_pulse_q) begin
          run_d = (mode == MODE_RUN);
          rem_d = (mode == MODE_BURST) ? burst_len : CNT_ONE;
          // A zero-length burst still snapshots and reports completion.
          if ((mode == MODE_BURST) && (burst_len == '0)) state_d = S_CAPTURE;
          else                                           state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!run_q) rem_d = rem_q - CNT_ONE;
        if (stop_s2_q || (!run_q && (rem_q == CNT_ONE))) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The model has had a full idle cycle to settle after its last step.
        hold_d  = probe_in;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    clk_en_d = (state_d == S_ACTIVE);
    busy_d   = (state_d != S_IDLE);
  end

  assign clk_en     = clk_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_count = count_q;
  assign probe_hold = hold_q;

endmodule
`default_nettype wire

// File: tb/tb_emu_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_emu_step_ctrl
// Description : Scoreboard bench for emu_step_ctrl with a narrow step counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emu_step_ctrl;
  localparam int N_CH      = 2;
  localparam int WIDTH     = 25;
  localparam int CNT_WIDTH = 4;
  localparam int PW        = N_CH * WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 go = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic [CNT_WIDTH-1:0] burst_len = '0;
  logic                 stop = 1'b0;
  logic                 clr_cnt = 1'b0;
  logic [PW-1:0]        probe_in = '0;
  logic                 clk_en, busy, done;
  logic [CNT_WIDTH-1:0] step_count;
  logic [PW-1:0]        probe_hold;

  emu_step_ctrl #(.N_CH(N_CH), .WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .burst_len(burst_len),
    .stop(stop), .clr_cnt(clr_cnt), .probe_in(probe_in), .clk_en(clk_en),
    .busy(busy), .done(done), .step_count(step_count), .probe_hold(probe_hold)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge number n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            first_e;
    int            steps;
    int            done_e;
    int            count;
    logic [PW-1:0] hold;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [PW-1:0] rand_probe();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // Monitor: observes the DUT and checks each completed command against the
  // oldest outstanding expectation.
  int   mon_seen = 0;
  int   mon_first = 0;
  int   mon_busy = 0;
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mon_seen = 0;
      mon_busy = 0;
    end else begin
      if (clk_en) begin
        if (mon_seen == 0) mon_first = cyc;
        mon_seen++;
      end
      if (busy) mon_busy++;
      if (done) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no command (edge %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("steps", mon_seen, mon_e.steps);
          if (mon_e.steps > 0) check("first_clk_en_edge", mon_first, mon_e.first_e);
          check("done_edge", cyc, mon_e.done_e);
          check("busy_cycles", mon_busy, mon_e.steps + 1);
          check("step_count", step_count, mon_e.count);
          check("probe_hold", probe_hold, mon_e.hold);
        end
        mon_seen = 0;
        mon_busy = 0;
      end
    end
  end

  // Issue one command and push its expected outcome. Offsets are edges
  // relative to edge k, the first edge that samples go high.
  //   go sampled at k -> first step at k+3, capture entered after the last
  //   step, done at k+4+steps. stop sampled at k+s ends stepping at k+s+2.
  task automatic run_cmd(input logic [1:0] m, input int len, input int stop_off,
                         input int clr_off, input bit rego, input logic [PW-1:0] hv);
    int   k, steps, done_e, last_e, cnt, c_off;
    exp_t e;
    @(negedge clk);
    mode      = m;
    burst_len = CNT_WIDTH'(len);
    go        = 1'b1;
    probe_in  = rand_probe();
    k = cyc + 1;
    if (m == 2'd2)      steps = stop_off - 1;
    else if (m == 2'd1) begin
      steps = len;
      if (stop_off > 0 && stop_off - 1 < len) steps = stop_off - 1;
    end else            steps = 1;
    c_off = clr_off;
    if (steps == 0) c_off = 0;
    else if (c_off > 3 + steps) c_off = 3 + steps;
    // Steps land on the counter at edges k+4 .. k+3+steps.
    if (c_off > 0) cnt = (3 + steps) - c_off;
    else           cnt = exp_count + steps;
    cnt = cnt % (1 << CNT_WIDTH);
    done_e    = k + 4 + steps;
    e.first_e = k + 3;
    e.steps   = steps;
    e.done_e  = done_e;
    e.count   = cnt;
    e.hold    = hv;
    q.push_back(e);
    last_e = (done_e > k + 10) ? done_e : k + 10;
    forever begin
      @(negedge clk);
      if (cyc + 1 > last_e) break;
      probe_in = (cyc + 1 == done_e) ? hv : rand_probe();
      if (cyc + 1 > k + 3) begin
        mode      = 2'($urandom);
        burst_len = CNT_WIDTH'($urandom);
      end
      if (stop_off > 0 && cyc + 1 == k + stop_off) stop = 1'b1;
      clr_cnt = (c_off > 0) && (cyc + 1 == k + c_off);
      if (rego) go = !((cyc + 1 >= k + 6) && (cyc + 1 < k + 9));
    end
    go      = 1'b0;
    stop    = 1'b0;
    clr_cnt = 1'b0;
    repeat (4) @(negedge clk);
    exp_count = cnt;
  endtask

  initial begin
    int k;
    logic [1:0] m;
    int len, so, co;

    repeat (3) @(negedge clk);
    check("reset_clk_en", clk_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_step_count", step_count, 0);
    check("reset_probe_hold", probe_hold, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single step, go held well beyond the command.
    run_cmd(2'd0, 0, 0, 0, 1'b0, rand_probe());
    // Burst of 5 with a known snapshot: ch0=0x0ABCDE, ch1=-3.
    run_cmd(2'd1, 5, 0, 0, 1'b0, {25'h1FFFFFD, 25'h0ABCDE});
    // Zero-length burst.
    run_cmd(2'd1, 0, 0, 0, 1'b0, rand_probe());
    // stop while idle must not disturb the next command.
    @(negedge clk); stop = 1'b1;
    repeat (3) @(negedge clk); stop = 1'b0;
    repeat (4) @(negedge clk);
    run_cmd(2'd3, 0, 0, 0, 1'b0, rand_probe());
    // Free run stopped after 22 steps, with a second go during the run.
    run_cmd(2'd2, 0, 23, 0, 1'b1, rand_probe());
    // Clear on the last step edge, then two 15-step bursts wrap to 14.
    run_cmd(2'd1, 8, 0, 11, 1'b0, rand_probe());
    run_cmd(2'd1, 15, 0, 0, 1'b0, rand_probe());
    run_cmd(2'd1, 15, 0, 0, 1'b0, rand_probe());
    // Clear on the first step edge of a burst.
    run_cmd(2'd1, 9, 0, 4, 1'b0, rand_probe());

    // Randomised commands.
    for (int i = 0; i < 25; i++) begin
      m   = 2'($urandom);
      len = $urandom_range(0, 15);
      so  = 0;
      co  = 0;
      if (m == 2'd2)                                  so = $urandom_range(4, 30);
      else if (m == 2'd1 && $urandom_range(0, 2) == 0) so = $urandom_range(4, 18);
      if ($urandom_range(0, 3) == 0) co = $urandom_range(4, 18);
      run_cmd(m, len, so, co, 1'b0, rand_probe());
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    mode = 2'd1; burst_len = CNT_WIDTH'(10); go = 1'b1; probe_in = rand_probe();
    k = cyc + 1;
    while (cyc < k + 6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk_en", clk_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_step_count", step_count, 0);
    check("async_rst_probe_hold", probe_hold, 0);
    go = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    repeat (20) @(negedge clk);
    check("async_rst_no_done_later", q.size(), 0);

    // Normal operation after the reset.
    run_cmd(2'd1, 3, 0, 0, 1'b0, rand_probe());
    repeat (5) @(negedge clk);
    check("pending_expectations", q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
